// File: rtl/branch_resolve_bht_if.sv
// rtl/branch_resolve_bht_if.sv - resolve request / prediction / status bundle for branch_resolve_bht
interface branch_resolve_bht_if #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int STAT_W = 16
);
  logic [PC_W-1:0]   if_pc;
  logic              if_pred_taken;
  logic              br_valid;
  logic [PC_W-1:0]   br_pc;
  logic              br_pred_taken;
  logic [6:0]        Opcode;
  logic [2:0]        funct;
  logic [XLEN-1:0]   Read_Data1;
  logic [XLEN-1:0]   Read_Data2;
  logic              br_taken;
  logic              IF_Flush;
  logic              br_illegal;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispredict_cnt;

  modport master (
    output if_pc, br_valid, br_pc, br_pred_taken, Opcode, funct, Read_Data1, Read_Data2,
    input  if_pred_taken, br_taken, IF_Flush, br_illegal, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, br_valid, br_pc, br_pred_taken, Opcode, funct, Read_Data1, Read_Data2,
    output if_pred_taken, br_taken, IF_Flush, br_illegal, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - RV32I conditional branch resolver with 2-bit bimodal predictor
module branch_resolve_bht #(
  parameter int         XLEN        = 32,
  parameter int         PC_W        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         STAT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_resolve_bht_if.slave bus
);
  localparam int         IDX_W      = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  br_idx;

  logic              br_taken_q, br_taken_d;
  logic              flush_q, flush_d;
  logic              illegal_q, illegal_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [1:0]        cnt_d;

  logic              req;
  logic              illegal_f3;
  logic              is_br;
  logic              dir;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign br_idx = bus.br_pc[IDX_W+1:2];

  // Reading the array directly gives the pre-update counter during a same-index write.
  assign bus.if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    req        = bus.br_valid && !flush_q && (bus.Opcode == OPC_BRANCH);
    illegal_f3 = (bus.funct == 3'b010) || (bus.funct == 3'b011);
    is_br      = req && !illegal_f3;

    dir = 1'b0;
    case (bus.funct)
      3'b000:  dir = (bus.Read_Data1 == bus.Read_Data2);
      3'b001:  dir = (bus.Read_Data1 != bus.Read_Data2);
      3'b100:  dir = ($signed(bus.Read_Data1) <  $signed(bus.Read_Data2));
      3'b101:  dir = ($signed(bus.Read_Data1) >= $signed(bus.Read_Data2));
      3'b110:  dir = (bus.Read_Data1 <  bus.Read_Data2);
      3'b111:  dir = (bus.Read_Data1 >= bus.Read_Data2);
      default: dir = 1'b0;
    endcase

    br_taken_d = is_br && dir;
    flush_d    = is_br && (dir != bus.br_pred_taken);
    illegal_d  = req && illegal_f3;

    cnt_d = bht_q[br_idx];
    if (dir && cnt_d != 2'b11) begin
      cnt_d = cnt_d + 2'b01;
    end else if (!dir && cnt_d != 2'b00) begin
      cnt_d = cnt_d - 2'b01;
    end

    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (is_br && branch_cnt_q != {STAT_W{1'b1}}) begin
      branch_cnt_d = branch_cnt_q + STAT_W'(1);
    end
    if (flush_d && mispred_cnt_q != {STAT_W{1'b1}}) begin
      mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q    <= 1'b0;
      flush_q       <= 1'b0;
      illegal_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else begin
      br_taken_q    <= br_taken_d;
      flush_q       <= flush_d;
      illegal_q     <= illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (is_br) begin
        bht_q[br_idx] <= cnt_d;
      end
    end
  end

  assign bus.br_taken       = br_taken_q;
  assign bus.IF_Flush       = flush_q;
  assign bus.br_illegal     = illegal_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - directed self-checking bench for branch_resolve_bht
module tb_branch_resolve_bht;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  branch_resolve_bht_if #(.XLEN(32), .PC_W(32), .STAT_W(16)) bus ();
  branch_resolve_bht_if #(.XLEN(32), .PC_W(32), .STAT_W(4))  bus4 ();

  // Narrow-counter instance sees the identical stimulus stream.
  assign bus4.if_pc         = bus.if_pc;
  assign bus4.br_valid      = bus.br_valid;
  assign bus4.br_pc         = bus.br_pc;
  assign bus4.br_pred_taken = bus.br_pred_taken;
  assign bus4.Opcode        = bus.Opcode;
  assign bus4.funct         = bus.funct;
  assign bus4.Read_Data1    = bus.Read_Data1;
  assign bus4.Read_Data2    = bus.Read_Data2;

  branch_resolve_bht #(.XLEN(32), .PC_W(32), .BHT_ENTRIES(16), .CNT_INIT(2'b01), .STAT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  branch_resolve_bht #(.XLEN(32), .PC_W(32), .BHT_ENTRIES(16), .CNT_INIT(2'b01), .STAT_W(4))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic pred, input logic [6:0] opc,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.br_valid      = 1'b1;
    bus.br_pc         = pc;
    bus.br_pred_taken = pred;
    bus.Opcode        = opc;
    bus.funct         = f3;
    bus.Read_Data1    = a;
    bus.Read_Data2    = b;
  endtask

  task automatic br(input logic [31:0] pc, input logic pred, input logic [6:0] opc,
                    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    drive_br(pc, pred, opc, f3, a, b);
    tick();
    bus.br_valid = 1'b0;
  endtask

  task automatic outs(input string tag, input logic t, input logic f, input logic il,
                      input int bc, input int mc);
    chk({tag, ".br_taken"}, bus.br_taken, t);
    chk({tag, ".IF_Flush"}, bus.IF_Flush, f);
    chk({tag, ".br_illegal"}, bus.br_illegal, il);
    chk({tag, ".branch_cnt"}, bus.branch_cnt, bc);
    chk({tag, ".mispredict_cnt"}, bus.mispredict_cnt, mc);
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    bus.if_pc = pc;
    #1;
    chk(tag, bus.if_pred_taken, exp);
  endtask

  initial begin
    bus.if_pc = '0; bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_pred_taken = 1'b0;
    bus.Opcode = '0; bus.funct = '0; bus.Read_Data1 = '0; bus.Read_Data2 = '0;

    // reset asserted between edges
    #2 rst_n = 1'b0;
    #1 outs("reset", 0, 0, 0, 0, 0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) pred_at("reset_pred", 32'(i * 4), 1'b0);
    tick();

    // BEQ equal, predicted not taken
    br(32'h10, 1'b0, BR, 3'b000, 32'd5, 32'd5);
    outs("beq", 1, 1, 0, 1, 1);
    pred_at("beq_bht", 32'h10, 1'b1);
    tick();
    outs("beq_clear", 0, 0, 0, 1, 1);

    // signed vs unsigned with rs1=-1, rs2=1
    br(32'h20, 1'b0, BR, 3'b100, 32'hFFFF_FFFF, 32'd1);
    outs("blt", 1, 1, 0, 2, 2);
    tick();
    br(32'h20, 1'b1, BR, 3'b110, 32'hFFFF_FFFF, 32'd1);
    outs("bltu", 0, 1, 0, 3, 3);
    tick();
    br(32'h20, 1'b0, BR, 3'b101, 32'hFFFF_FFFF, 32'd1);
    outs("bge", 0, 0, 0, 4, 3);
    tick();
    br(32'h20, 1'b1, BR, 3'b111, 32'hFFFF_FFFF, 32'd1);
    outs("bgeu", 1, 0, 0, 5, 3);
    tick();
    br(32'h24, 1'b0, BR, 3'b001, 32'd5, 32'd5);
    outs("bne", 0, 0, 0, 6, 3);
    pred_at("idx8_bht", 32'h20, 1'b0);
    tick();

    // saturation at 11, then one not-taken must leave it predicting taken
    for (int i = 0; i < 4; i++) br(32'h40, 1'b1, BR, 3'b000, 32'd7, 32'd7);
    outs("sat4", 1, 0, 0, 10, 3);
    pred_at("sat_bht", 32'h40, 1'b1);
    br(32'h40, 1'b1, BR, 3'b001, 32'd7, 32'd7);
    outs("sat_dec", 0, 1, 0, 11, 4);
    pred_at("sat_dec_bht", 32'h40, 1'b1);

    // request while IF_Flush is high is squashed
    br(32'h44, 1'b0, BR, 3'b000, 32'd1, 32'd1);
    outs("squash", 0, 0, 0, 11, 4);
    pred_at("squash_bht", 32'h44, 1'b0);

    // 0x80 aliases entry 0 (now 10); bring it to 01 first
    br(32'h80, 1'b1, BR, 3'b001, 32'd3, 32'd3);
    outs("alias_dec", 0, 1, 0, 12, 5);
    tick();
    pred_at("rdw_before", 32'h80, 1'b0);
    drive_br(32'h80, 1'b0, BR, 3'b000, 32'd9, 32'd9);
    #1 chk("rdw_update_cycle", bus.if_pred_taken, 1'b0);
    tick();
    bus.br_valid = 1'b0;
    #1 chk("rdw_next_cycle", bus.if_pred_taken, 1'b1);
    outs("rdw", 1, 1, 0, 13, 6);
    tick();

    // illegal funct3 and non-branch opcode
    br(32'h30, 1'b0, BR, 3'b010, 32'd5, 32'd5);
    outs("illegal", 0, 0, 1, 13, 6);
    pred_at("illegal_bht", 32'h30, 1'b0);
    tick();
    chk("illegal_clear", bus.br_illegal, 1'b0);
    br(32'h30, 1'b0, ALU, 3'b000, 32'd5, 32'd5);
    outs("non_branch", 0, 0, 0, 13, 6);
    pred_at("non_branch_bht", 32'h30, 1'b0);
    tick();

    // 20 mispredicts: 16-bit counters keep counting, 4-bit ones hold at F
    for (int i = 0; i < 20; i++) begin
      br(32'h0, 1'b0, BR, 3'b000, 32'd2, 32'd2);
      tick();
    end
    chk("wide_branch_cnt", bus.branch_cnt, 33);
    chk("wide_mispredict_cnt", bus.mispredict_cnt, 26);
    chk("narrow_branch_cnt", bus4.branch_cnt, 4'hF);
    chk("narrow_mispredict_cnt", bus4.mispredict_cnt, 4'hF);

    // asynchronous reset while outputs are active
    br(32'h10, 1'b0, BR, 3'b000, 32'd4, 32'd4);
    chk("pre_reset_flush", bus.IF_Flush, 1'b1);
    #2 rst_n = 1'b0;
    #1 outs("async_reset", 0, 0, 0, 0, 0);
    chk("async_reset_narrow_mc", bus4.mispredict_cnt, 0);
    pred_at("async_reset_bht", 32'h10, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
